// File: rtl/comm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comm_pkg
// Description : Shared types and constants for the serial frame receiver.
//               COMM_RX_PARITY_EN adds the PARITY state.
// Revision    : 1.0 - initial release
// ============================================================================
package comm_pkg;

    localparam int   FRAME_DATA_BITS = 6;
    localparam int   MSG_W           = 4;
    localparam int   SEL_W           = 2;
    localparam logic IDLE_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef COMM_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/comm_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : comm_bit_timer
// Description : Bit-period counter with mid-bit and full-bit ticks.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic mid_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || full_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign mid_tick  = (r_cnt == CNT_W'(BIT_CYCLES / 2 - 1));
    assign full_tick = (r_cnt == CNT_W'(BIT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/comm_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : comm_frame_rx
// Description : Serial frame receiver (start, sel[1:0], msg[3:0], stop) with a
//               per-channel message store. COMM_RX_PARITY_EN adds even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module comm_frame_rx
    import comm_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_in,
    output logic [MSG_W-1:0]       msg_out,
    output logic [SEL_W-1:0]       sel_out,
    output logic [4*MSG_W-1:0]     ch_bus,
    output logic                   msg_valid,
    output logic                   frame_err
);

    logic                        r_sync1;
    logic                        r_sync2;
    logic                        r_sync_prev;
    state_t                      r_state;
    state_t                      w_next;
    logic [2:0]                  r_bit_idx;
    logic [FRAME_DATA_BITS-1:0]  r_shift;
    logic [MSG_W-1:0]            r_msg;
    logic [SEL_W-1:0]            r_sel;
    logic [4*MSG_W-1:0]          r_ch;
    logic                        r_valid;
    logic                        r_err;

    logic w_fall;
    logic w_mid_tick;
    logic w_full_tick;
    logic w_timer_clear;
    logic w_shift_en;
    logic w_accept;
    logic w_reject;
    logic w_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= IDLE_LEVEL;
            r_sync2     <= IDLE_LEVEL;
            r_sync_prev <= IDLE_LEVEL;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    assign w_fall = r_sync_prev & ~r_sync2;

    comm_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_timer_clear),
        .mid_tick  (w_mid_tick),
        .full_tick (w_full_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall) w_next = ST_START;
            ST_START: if (w_mid_tick) w_next = r_sync2 ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_full_tick && (r_bit_idx == 3'(FRAME_DATA_BITS - 1))) begin
`ifdef COMM_RX_PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
`ifdef COMM_RX_PARITY_EN
            ST_PARITY: if (w_full_tick) w_next = ST_STOP;
`endif
            ST_STOP:  if (w_full_tick) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // START re-arms the timer at its mid-bit sample so later samples land mid-bit.
    always_comb begin
        w_timer_clear = ((r_state == ST_IDLE) && w_fall) ||
                        ((r_state == ST_START) && w_mid_tick);
        w_shift_en    = (r_state == ST_DATA) && w_full_tick;
        w_accept      = (r_state == ST_STOP) && w_full_tick && r_sync2 && !w_par_err;
        w_reject      = (r_state == ST_STOP) && w_full_tick && !w_accept;
    end

`ifdef COMM_RX_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_err <= 1'b0;
        end else if ((r_state == ST_PARITY) && w_full_tick) begin
            r_par_err <= ^{r_shift, r_sync2};
        end
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (w_timer_clear) begin
            r_bit_idx <= '0;
        end else if (w_shift_en) begin
            r_bit_idx <= r_bit_idx + 3'd1;
            r_shift   <= {r_shift[FRAME_DATA_BITS-2:0], r_sync2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg   <= '0;
            r_sel   <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= w_accept;
            r_err   <= w_reject;
            if (w_accept) begin
                r_msg <= r_shift[MSG_W-1:0];
                r_sel <= r_shift[FRAME_DATA_BITS-1:MSG_W];
                for (int i = 0; i < 4; i++) begin
                    if (r_shift[FRAME_DATA_BITS-1:MSG_W] == SEL_W'(i)) begin
                        r_ch[i*MSG_W +: MSG_W] <= r_shift[MSG_W-1:0];
                    end
                end
            end
        end
    end

    assign msg_out   = r_msg;
    assign sel_out   = r_sel;
    assign ch_bus    = r_ch;
    assign msg_valid = r_valid;
    assign frame_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_comm_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_comm_frame_rx
// Description : Self-checking bench for comm_frame_rx (BIT_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comm_frame_rx;

    localparam int BC = 4;

    logic        clk;
    logic        rst_n;
    logic        rx_in;
    logic [3:0]  msg_out;
    logic [1:0]  sel_out;
    logic [15:0] ch_bus;
    logic        msg_valid;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  msg;
        logic        stop;
        logic        exp_valid;
        logic [3:0]  exp_msg;
        logic [1:0]  exp_sel;
        logic [15:0] exp_ch;
    } vec_t;

    vec_t vecs[6];

    comm_frame_rx #(.BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .msg_out   (msg_out),
        .sel_out   (sel_out),
        .ch_bus    (ch_bus),
        .msg_valid (msg_valid),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (msg_valid) n_valid++;
        if (frame_err) n_err++;
        if (msg_valid && frame_err) n_both++;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] sel, input logic [3:0] msg,
                              input logic stop, input logic par_flip);
        send_bit(1'b0);
        send_bit(sel[1]);
        send_bit(sel[0]);
        for (int i = 3; i >= 0; i--) send_bit(msg[i]);
`ifdef COMM_RX_PARITY_EN
        send_bit((^{sel, msg}) ^ par_flip);
`else
        if (par_flip) rx_in = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] m,
                                 input logic [1:0] s, input logic [15:0] c);
        check({tag, " msg_out"}, {12'h0, msg_out}, {12'h0, m});
        check({tag, " sel_out"}, {14'h0, sel_out}, {14'h0, s});
        check({tag, " ch_bus"},  ch_bus, c);
    endtask

    initial begin
        int v0;
        int e0;

        vecs[0] = '{sel: 2'b10, msg: 4'b0100, stop: 1'b1, exp_valid: 1'b1, exp_msg: 4'h4, exp_sel: 2'd2, exp_ch: 16'h0400};
        vecs[1] = '{sel: 2'b01, msg: 4'b0010, stop: 1'b0, exp_valid: 1'b0, exp_msg: 4'h4, exp_sel: 2'd2, exp_ch: 16'h0400};
        vecs[2] = '{sel: 2'b00, msg: 4'b0001, stop: 1'b1, exp_valid: 1'b1, exp_msg: 4'h1, exp_sel: 2'd0, exp_ch: 16'h0401};
        vecs[3] = '{sel: 2'b11, msg: 4'b1000, stop: 1'b1, exp_valid: 1'b1, exp_msg: 4'h8, exp_sel: 2'd3, exp_ch: 16'h8401};
        vecs[4] = '{sel: 2'b01, msg: 4'b1111, stop: 1'b1, exp_valid: 1'b1, exp_msg: 4'hF, exp_sel: 2'd1, exp_ch: 16'h84F1};
        vecs[5] = '{sel: 2'b10, msg: 4'b0000, stop: 1'b1, exp_valid: 1'b1, exp_msg: 4'h0, exp_sel: 2'd2, exp_ch: 16'h80F1};

        rx_in = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 4'h0, 2'd0, 16'h0000);
        check("reset msg_valid", {15'h0, msg_valid}, 16'h0);
        check("reset frame_err", {15'h0, frame_err}, 16'h0);
        rst_n = 1'b1;
        idle(6);

        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            e0 = n_err;
            send_frame(vecs[i].sel, vecs[i].msg, vecs[i].stop, 1'b0);
            idle(10);
            check($sformatf("vec%0d valid pulses", i), 16'(n_valid - v0), {15'h0, vecs[i].exp_valid});
            check($sformatf("vec%0d err pulses", i), 16'(n_err - e0), {15'h0, ~vecs[i].exp_valid});
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_msg, vecs[i].exp_sel, vecs[i].exp_ch);
        end

        // Glitch start: low for a single cycle only.
        v0 = n_valid;
        e0 = n_err;
        rx_in = 1'b0;
        @(posedge clk);
        #1;
        idle(12);
        check("false start valid", 16'(n_valid - v0), 16'h0);
        check("false start err", 16'(n_err - e0), 16'h0);
        check_outputs("false start", 4'h0, 2'd2, 16'h80F1);

        v0 = n_valid;
        send_frame(2'b00, 4'b0101, 1'b1, 1'b0);
        idle(10);
        check("after glitch valid", 16'(n_valid - v0), 16'h1);
        check_outputs("after glitch", 4'h5, 2'd0, 16'h80F5);

`ifdef COMM_RX_PARITY_EN
        v0 = n_valid;
        e0 = n_err;
        send_frame(2'b01, 4'b0011, 1'b1, 1'b1);
        idle(10);
        check("bad parity valid", 16'(n_valid - v0), 16'h0);
        check("bad parity err", 16'(n_err - e0), 16'h1);
        check_outputs("bad parity", 4'h5, 2'd0, 16'h80F5);
        v0 = n_valid;
        e0 = n_err;
        send_frame(2'b01, 4'b0011, 1'b1, 1'b0);
        idle(10);
        check("good parity valid", 16'(n_valid - v0), 16'h1);
        check("good parity err", 16'(n_err - e0), 16'h0);
        check("good parity ch[7:4]", {12'h0, ch_bus[7:4]}, 16'h0003);
        check_outputs("good parity", 4'h3, 2'd1, 16'h8035);
`endif

        // Abort mid-frame: start, sel1, sel0, msg3, then part of msg2 (DATA bit 3).
        v0 = n_valid;
        e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx_in = 1'b1;
        #2;
        check_outputs("mid reset", 4'h0, 2'd0, 16'h0000);
        check("mid reset msg_valid", {15'h0, msg_valid}, 16'h0);
        check("mid reset frame_err", {15'h0, frame_err}, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(12);
        check("post reset valid", 16'(n_valid - v0), 16'h0);
        check("post reset err", 16'(n_err - e0), 16'h0);

        // Back-to-back frames with no idle gap between them.
        v0 = n_valid;
        e0 = n_err;
        send_frame(2'b00, 4'b0001, 1'b1, 1'b0);
        send_frame(2'b11, 4'b1000, 1'b1, 1'b0);
        idle(10);
        check("b2b valid pulses", 16'(n_valid - v0), 16'h2);
        check("b2b err pulses", 16'(n_err - e0), 16'h0);
        check_outputs("b2b", 4'h8, 2'd3, 16'h8001);

        check("valid and err overlap", 16'(n_both), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
